// File: rtl/fmc_initiator_pkg.sv
// Shared types and constants for the APB-to-FMC initiator bridge.
package fmc_initiator_pkg;

  localparam int FMC_AD_WIDTH  = 16;
  localparam int FMC_AHI_WIDTH = 7;
  localparam int WAIT_CNT_W    = 8;
  localparam int LAT_CNT_W     = 4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_LAT   = 3'd2,
    S_DATA0 = 3'd3,
    S_DATA1 = 3'd4,
    S_TURN  = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  // Every FMC output pin is registered together so it can only move on a fall tick.
  typedef struct packed {
    logic                     ne_n;
    logic                     nadv;
    logic                     noe;
    logic                     nwe;
    logic [1:0]               nbl;
    logic                     ad_oe;
    logic [FMC_AD_WIDTH-1:0]  ad_out;
    logic [FMC_AHI_WIDTH-1:0] a_hi;
  } fmc_bus_t;

  localparam fmc_bus_t FMC_BUS_IDLE = '{
    ne_n: 1'b1, nadv: 1'b1, noe: 1'b1, nwe: 1'b1,
    nbl: 2'b11, ad_oe: 1'b0, ad_out: '0, a_hi: '0
  };

endpackage

// File: rtl/fmc_clk_divider.sv
// Divide-by-two FMC clock with strobes marking the clk edge on which it falls or rises.
module fmc_clk_divider (
  input  logic clk,
  input  logic rst,
  output logic fmc_clk,
  output logic fall_tick,
  output logic rise_tick
);

  logic fmc_clk_q, fmc_clk_d;

  always_comb fmc_clk_d = ~fmc_clk_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) fmc_clk_q <= 1'b0;
    else     fmc_clk_q <= fmc_clk_d;
  end

  assign fmc_clk   = fmc_clk_q;
  assign fall_tick = fmc_clk_q;
  assign rise_tick = ~fmc_clk_q;

endmodule

// File: rtl/apb_fmc_initiator.sv
// APB completer that replays each 32-bit access as a two-beat multiplexed 16-bit FMC burst.
module apb_fmc_initiator
  import fmc_initiator_pkg::*;
#(
  parameter int ADDR_WIDTH   = 24,
  parameter int DATLAT       = 1,
  parameter int WAIT_TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     psel,
  input  logic                     penable,
  input  logic                     pwrite,
  input  logic [ADDR_WIDTH-1:0]    paddr,
  input  logic [31:0]              pwdata,
  input  logic [3:0]               pstrb,
  output logic                     pready,
  output logic [31:0]              prdata,
  output logic                     pslverr,
  output logic                     fmc_clk,
  output logic                     fmc_ne_n,
  output logic                     fmc_nl_nadv,
  output logic                     fmc_noe,
  output logic                     fmc_nwe,
  output logic [1:0]               fmc_nbl,
  output logic [FMC_AHI_WIDTH-1:0] fmc_a_hi,
  output logic [FMC_AD_WIDTH-1:0]  fmc_ad_out,
  output logic                     fmc_ad_oe,
  input  logic [FMC_AD_WIDTH-1:0]  fmc_ad_in,
  input  logic                     fmc_nwait
);

  localparam logic [LAT_CNT_W-1:0] LAT_LAST = LAT_CNT_W'(DATLAT);
  localparam logic [WAIT_CNT_W:0]  TMO      = (WAIT_CNT_W+1)'(WAIT_TIMEOUT);

  logic fall_tick, rise_tick;

  fmc_clk_divider u_div (
    .clk       (clk),
    .rst       (rst),
    .fmc_clk   (fmc_clk),
    .fall_tick (fall_tick),
    .rise_tick (rise_tick)
  );

  state_t                 state_q, state_d;
  logic                   req_q, req_d;
  logic [LAT_CNT_W-1:0]   lat_cnt_q, lat_cnt_d;
  logic [WAIT_CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic                   beat_ok_q, beat_ok_d;
  logic                   tout_q, tout_d;
  fmc_bus_t               bus_q, bus_d;
  logic                   pready_q, pready_d;
  logic [31:0]            prdata_q, prdata_d;
  logic                   pslverr_q, pslverr_d;

  logic [ADDR_WIDTH-1:1]  addr_q, addr_d;
  logic [31:0]            wdata_q, wdata_d;
  logic [3:0]             strb_q, strb_d;
  logic                   wr_q, wr_d;
  logic [31:0]            rd_buf_q, rd_buf_d;

  logic [WAIT_CNT_W:0]    wait_nxt;
  logic                   unused_paddr;

  assign unused_paddr = paddr[0];
  assign wait_nxt     = {1'b0, wait_cnt_q} + (WAIT_CNT_W+1)'(1);

  // Writes own the AD bus during data beats; reads release it and enable both lanes.
  function automatic fmc_bus_t drive_beat(input fmc_bus_t cur, input logic wr,
                                          input logic [15:0] data, input logic [1:0] strb);
    fmc_bus_t b;
    b      = cur;
    b.nadv = 1'b1;
    if (wr) begin
      b.ad_oe  = 1'b1;
      b.ad_out = data;
      b.nbl    = ~strb;
    end else begin
      b.ad_oe  = 1'b0;
      b.nbl    = 2'b00;
    end
    return b;
  endfunction

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    lat_cnt_d  = lat_cnt_q;
    wait_cnt_d = wait_cnt_q;
    beat_ok_d  = beat_ok_q;
    tout_d     = tout_q;
    bus_d      = bus_q;
    pready_d   = pready_q;
    prdata_d   = prdata_q;
    pslverr_d  = pslverr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    strb_d     = strb_q;
    wr_d       = wr_q;
    rd_buf_d   = rd_buf_q;

    case (state_q)
      S_IDLE: begin
        if (!req_q && psel && penable && !pready_q) begin
          req_d   = 1'b1;
          addr_d  = paddr[ADDR_WIDTH-1:1];
          wdata_d = pwdata;
          strb_d  = pstrb;
          wr_d    = pwrite;
        end else if (req_q && fall_tick) begin
          req_d        = 1'b0;
          state_d      = S_ADDR;
          bus_d.ne_n   = 1'b0;
          bus_d.nadv   = 1'b0;
          bus_d.noe    = wr_q;
          bus_d.nwe    = ~wr_q;
          bus_d.nbl    = 2'b11;
          bus_d.ad_oe  = 1'b1;
          bus_d.ad_out = addr_q[16:1];
          bus_d.a_hi   = addr_q[23:17];
        end
      end

      S_ADDR: begin
        if (fall_tick) begin
          if (DATLAT == 0) begin
            state_d = S_DATA0;
            bus_d   = drive_beat(bus_q, wr_q, wdata_q[15:0], strb_q[1:0]);
          end else begin
            state_d    = S_LAT;
            lat_cnt_d  = LAT_CNT_W'(1);
            bus_d.nadv = 1'b1;
            if (wr_q) bus_d.ad_out = wdata_q[15:0];
            else      bus_d.ad_oe  = 1'b0;
          end
        end
      end

      S_LAT: begin
        if (fall_tick) begin
          if (lat_cnt_q == LAT_LAST) begin
            state_d = S_DATA0;
            bus_d   = drive_beat(bus_q, wr_q, wdata_q[15:0], strb_q[1:0]);
          end else begin
            lat_cnt_d = lat_cnt_q + LAT_CNT_W'(1);
          end
        end
      end

      S_DATA0, S_DATA1: begin
        // Beat outcome is decided mid-cycle on the rise tick and acted on at the next fall tick.
        if (rise_tick && !beat_ok_q && !tout_q) begin
          if (fmc_nwait) begin
            beat_ok_d  = 1'b1;
            wait_cnt_d = '0;
            if (state_q == S_DATA0) rd_buf_d[15:0]  = fmc_ad_in;
            else                    rd_buf_d[31:16] = fmc_ad_in;
          end else begin
            wait_cnt_d = wait_nxt[WAIT_CNT_W-1:0];
            if (wait_nxt >= TMO) tout_d = 1'b1;
          end
        end
        if (fall_tick) begin
          if (beat_ok_q) begin
            beat_ok_d = 1'b0;
            if (state_q == S_DATA0) begin
              state_d = S_DATA1;
              bus_d   = drive_beat(bus_q, wr_q, wdata_q[31:16], strb_q[3:2]);
            end else begin
              state_d = S_TURN;
              bus_d   = FMC_BUS_IDLE;
            end
          end else if (tout_q) begin
            state_d = S_TURN;
            bus_d   = FMC_BUS_IDLE;
          end
        end
      end

      S_TURN: begin
        if (fall_tick) begin
          state_d    = S_DONE;
          pready_d   = 1'b1;
          pslverr_d  = tout_q;
          if (tout_q)     prdata_d = '0;
          else if (!wr_q) prdata_d = rd_buf_q;
          tout_d     = 1'b0;
          wait_cnt_d = '0;
        end
      end

      S_DONE: begin
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        state_d   = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      req_q      <= 1'b0;
      lat_cnt_q  <= '0;
      wait_cnt_q <= '0;
      beat_ok_q  <= 1'b0;
      tout_q     <= 1'b0;
      bus_q      <= FMC_BUS_IDLE;
      pready_q   <= 1'b0;
      prdata_q   <= '0;
      pslverr_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      lat_cnt_q  <= lat_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      beat_ok_q  <= beat_ok_d;
      tout_q     <= tout_d;
      bus_q      <= bus_d;
      pready_q   <= pready_d;
      prdata_q   <= prdata_d;
      pslverr_q  <= pslverr_d;
    end
  end

  always_ff @(posedge clk) begin
    addr_q   <= addr_d;
    wdata_q  <= wdata_d;
    strb_q   <= strb_d;
    wr_q     <= wr_d;
    rd_buf_q <= rd_buf_d;
  end

  assign pready      = pready_q;
  assign prdata      = prdata_q;
  assign pslverr     = pslverr_q;
  assign fmc_ne_n    = bus_q.ne_n;
  assign fmc_nl_nadv = bus_q.nadv;
  assign fmc_noe     = bus_q.noe;
  assign fmc_nwe     = bus_q.nwe;
  assign fmc_nbl     = bus_q.nbl;
  assign fmc_a_hi    = bus_q.a_hi;
  assign fmc_ad_out  = bus_q.ad_out;
  assign fmc_ad_oe   = bus_q.ad_oe;

endmodule
